// File: rtl/alu_operand_sel_pipe.sv
// alu_operand_sel_pipe: indexed operand select registered behind a 2-entry skid buffer
module alu_operand_sel_pipe #(
  parameter int          WIDTH       = 32,
  parameter int          NUM_SRC     = 5,
  parameter int          SEL_W       = 3,
  parameter logic [31:0] ILLEGAL_VAL = 32'hDEADBEEF,
  parameter int          CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC*WIDTH-1:0] i_src_flat,
  input  logic [SEL_W-1:0]         i_sel,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_out_data,
  output logic                     o_out_err,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [CNT_W-1:0]         o_err_count
);
  logic [WIDTH-1:0] w_sel_d, r_main_d, r_skid_d;
  logic             w_sel_ok, w_acc, w_main_free;
  logic             r_main_v, r_main_e, r_skid_v, r_skid_e, r_in_ready;
  logic [CNT_W-1:0] r_cnt;
  // equality scan keeps out-of-range selects from indexing past the packed bus
  always_comb begin
    w_sel_d  = WIDTH'(ILLEGAL_VAL);
    w_sel_ok = 1'b0;
    for (int k = 0; k < NUM_SRC; k++)
      if (i_sel == SEL_W'(k)) begin
        w_sel_d  = i_src_flat[k*WIDTH +: WIDTH];
        w_sel_ok = 1'b1;
      end
  end
  assign w_acc       = i_in_valid && r_in_ready && !i_flush;
  assign w_main_free = !r_main_v || i_out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_v   <= 1'b0;
      r_main_d   <= '0;
      r_main_e   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_skid_d   <= '0;
      r_skid_e   <= 1'b0;
      r_in_ready <= 1'b1;
      r_cnt      <= '0;
    end else begin
      if (w_acc && !w_sel_ok && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
      if (i_flush) begin
        r_main_v   <= 1'b0;
        r_main_e   <= 1'b0;
        r_skid_v   <= 1'b0;
        r_in_ready <= 1'b1;
      end else begin
        r_in_ready <= w_main_free || !(r_skid_v || w_acc);
        if (w_main_free) begin
          if (r_skid_v) begin
            r_main_d <= r_skid_d;
            r_main_e <= r_skid_e;
            r_skid_v <= 1'b0;
          end else if (w_acc) begin
            r_main_v <= 1'b1;
            r_main_d <= w_sel_d;
            r_main_e <= !w_sel_ok;
          end else r_main_v <= 1'b0;
        end else if (w_acc) begin
          r_skid_v <= 1'b1;
          r_skid_d <= w_sel_d;
          r_skid_e <= !w_sel_ok;
        end
      end
    end
  end
  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_main_v;
  assign o_out_data  = r_main_d;
  assign o_out_err   = r_main_e;
  assign o_err_count = r_cnt;
endmodule
